load_align_unit: RTL

- Sequential successor to the combinational load-extension stage in the MEM path.
- Accepts a load request carrying a byte address and funct3.
- Fetches one or two XLEN-wide words from data memory over a req/gnt/rvalid interface.
- Extracts the addressed bytes, sign- or zero-extends them, and returns the result to writeback on a valid/ready handshake.

---
 rtl/load_align_unit.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/load_align_unit.sv
// Load alignment unit: fetches one or two memory words, extracts the addressed bytes and extends them.
// Build option LOAD_ALIGN_SPLIT_EN: word-crossing loads run as two beats; otherwise they fault as misaligned.
module load_align_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [2:0]      req_funct3,
    input  logic [4:0]      req_rd,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [4:0]      rsp_rd,
    output logic            rsp_illegal,
    output logic            rsp_misaligned
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    // state | meaning
    // IDLE  | ready for a request
    // REQ0  | first word requested, waiting for grant
    // WAIT0 | first word granted, waiting for read data
    // REQ1  | second word requested (crossing loads, split build only)
    // WAIT1 | second word granted, waiting for read data
    // RESP  | result presented until writeback accepts it
    typedef enum logic [2:0] {
        IDLE, REQ0, WAIT0,
`ifdef LOAD_ALIGN_SPLIT_EN
        REQ1, WAIT1,
`endif
        RESP
    } state_t;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b111) || ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
    endfunction

    function automatic logic crosses(input logic [OFFW-1:0] off, input logic [1:0] sz);
        logic [4:0] span;
        span = 5'(off) + (5'd1 << sz);
        return span > 5'(NB);
    endfunction

    function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] raw_w);
        case (f3)
            3'b000:  return XLEN'($signed(raw_w[7:0]));
            3'b100:  return XLEN'(raw_w[7:0]);
            3'b001:  return XLEN'($signed(raw_w[15:0]));
            3'b101:  return XLEN'(raw_w[15:0]);
            3'b010:  return XLEN'($signed(raw_w[31:0]));
            3'b110:  return XLEN'(raw_w[31:0]);
            3'b011:  return raw_w;
            default: return '0;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              accept;
    logic              load_rsp;
    logic [XLEN-1:0]   rsp_data_d;
    logic [4:0]        rsp_rd_d;
    logic              ill_d;
    logic [OFFW-1:0]   off_q;
    logic [XLEN-1:0]   word_addr;
    logic [2*XLEN-1:0] pair;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   ext;

    assign off_q     = addr_q[OFFW-1:0];
    assign word_addr = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign raw       = XLEN'(pair >> {off_q, 3'b000});
    assign ext       = extend(f3_q, raw);
    assign rsp_valid = (state_q == RESP);

`ifdef LOAD_ALIGN_SPLIT_EN
    logic [XLEN-1:0] w0_q;
    logic            capture_w0;
    logic            cross_q;

    assign cross_q        = crosses(off_q, f3_q[1:0]);
    assign pair           = (state_q == WAIT1) ? {mem_rdata, w0_q} : {{XLEN{1'b0}}, mem_rdata};
    assign rsp_misaligned = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w0_q <= '0;
        end else if (capture_w0) begin
            w0_q <= mem_rdata;
        end
    end
`else
    logic mis_d;
    logic rsp_mis_q;

    assign pair           = {{XLEN{1'b0}}, mem_rdata};
    assign rsp_misaligned = rsp_mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_mis_q <= 1'b0;
        end else if (load_rsp) begin
            rsp_mis_q <= mis_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        accept     = 1'b0;
        load_rsp   = 1'b0;
        rsp_data_d = '0;
        rsp_rd_d   = rd_q;
        ill_d      = 1'b0;
`ifdef LOAD_ALIGN_SPLIT_EN
        capture_w0 = 1'b0;
`else
        mis_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept   = 1'b1;
                    rsp_rd_d = req_rd;
                    if (f3_illegal(req_funct3)) begin
                        state_d  = RESP;
                        load_rsp = 1'b1;
                        ill_d    = 1'b1;
                    end
`ifndef LOAD_ALIGN_SPLIT_EN
                    else if (crosses(req_addr[OFFW-1:0], req_funct3[1:0])) begin
                        state_d  = RESP;
                        load_rsp = 1'b1;
                        mis_d    = 1'b1;
                    end
`endif
                    else begin
                        state_d = REQ0;
                    end
                end
            end
            REQ0: begin
                mem_req  = 1'b1;
                mem_addr = word_addr;
                if (mem_gnt) state_d = WAIT0;
            end
            WAIT0: begin
                if (mem_rvalid) begin
`ifdef LOAD_ALIGN_SPLIT_EN
                    if (cross_q) begin
                        state_d    = REQ1;
                        capture_w0 = 1'b1;
                    end else begin
                        state_d    = RESP;
                        load_rsp   = 1'b1;
                        rsp_data_d = ext;
                    end
`else
                    state_d    = RESP;
                    load_rsp   = 1'b1;
                    rsp_data_d = ext;
`endif
                end
            end
`ifdef LOAD_ALIGN_SPLIT_EN
            REQ1: begin
                mem_req  = 1'b1;
                mem_addr = word_addr + XLEN'(NB);
                if (mem_gnt) state_d = WAIT1;
            end
            WAIT1: begin
                if (mem_rvalid) begin
                    state_d    = RESP;
                    load_rsp   = 1'b1;
                    rsp_data_d = ext;
                end
            end
`endif
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            f3_q        <= '0;
            rd_q        <= '0;
            rsp_data    <= '0;
            rsp_rd      <= '0;
            rsp_illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= req_addr;
                f3_q   <= req_funct3;
                rd_q   <= req_rd;
            end
            if (load_rsp) begin
                rsp_data    <= rsp_data_d;
                rsp_rd      <= rsp_rd_d;
                rsp_illegal <= ill_d;
            end
        end
    end
endmodule
